axi4_lite_slave_regs: RTL and testbench
=======================================

Name: axi4_lite_slave_regs

Overview:
AXI4-Lite responder that terminates the AW/W/B write and AR/R read channels from the team's AXI4-Lite master. It holds four 32-bit software registers. The write and read paths run independently. Register contents are also driven out in parallel so downstream logic (peripheral control) can consume them directly.

Parameters:
DATA_W, 32, data and register width
NUM_REGS, 4, register count; fixed by 4-bit address, word index = addr[3:2]

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWADDR  in  4  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  32  write data
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  4  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  32  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
slv_regs  out  128  {reg3,reg2,reg1,reg0}, live register contents

Behaviour:
- One clock (ACLK). Reset is asynchronous and active-low (ARESETn).
- Reset values: all registers 0; AWREADY=1, WREADY=1, ARREADY=1; BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0. Internal capture flags cleared; both FSMs idle.
- Reset asserted mid-transaction aborts it: no register write, no pending B/R response.
- Addressing: index = addr[3:2]; addr[1:0] ignored. Addresses 0x1-0x3 alias reg0, and so on.
- Responses: BRESP and RRESP are always 2'b00 (OKAY); no error decode.
- Write FSM states: WR_IDLE, WR_RESP.
  - WR_IDLE: AWREADY = !aw_held; WREADY = !w_held.
  - AW handshake latches AWADDR and sets aw_held. W handshake latches WDATA and sets w_held.
  - AW and W may arrive in the same cycle or in any order, with any gap.
  - On the edge where both are available (held, or handshaking this cycle): write the register, clear both flags, go to WR_RESP.
  - WR_RESP: AWREADY=0, WREADY=0, BVALID=1. On BVALID&&BREADY go to WR_IDLE and drop BVALID.
  - Latency: AW and W both accepted in cycle N → register updated at the end of N, BVALID high in N+1.
  - BVALID holds indefinitely while BREADY=0. No new AW or W is accepted until B completes (one outstanding write).
- Read FSM states: RD_IDLE, RD_DATA.
  - RD_IDLE: ARREADY=1. On ARVALID, RDATA is registered from the selected register and the FSM goes to RD_DATA.
  - RD_DATA: ARREADY=0, RVALID=1, RDATA stable. On RREADY go to RD_IDLE.
  - Latency: AR accepted in cycle N → RVALID in N+1.
  - One outstanding read.
- Simultaneous read and write to the same register in the same cycle: read returns the pre-write value. The write is visible to any later read.
- Read and write FSMs never stall each other.
- slv_regs reflects a register write one cycle after the completing handshake edge, same timing as the register itself.

Decomposition:
- Shared package axi4_lite_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR constants, DATA_W/ADDR_W constants, and the write/read state enums. The existing master also uses this package.
- One sub-module: axi4_lite_regfile. It is a 4x32 array with one synchronous write port, one combinational read port, and async reset to 0.
- The slave owns the handshake FSMs and instantiates the regfile.

Test Plan:
1. AWADDR=0x4, AWVALID=1, WDATA=0xDEADBEEF, WVALID=1 in same cycle, BREADY=1 → BVALID=1 next cycle, BRESP=00; slv_regs[63:32]=0xDEADBEEF.
2. AWADDR=0x8 accepted, WDATA=0x12345678 sent 3 cycles later → AWREADY=0 during the gap, WREADY=1; BVALID 1 cycle after W; reg2=0x12345678. Repeat with W first and AW 3 cycles later.
3. Write completes with BREADY=0 for 5 cycles → BVALID stays 1; AWREADY=WREADY=0 throughout; new AWVALID is ignored until BREADY.
4. Read ARADDR=0x7 after reg1=0xA5A5A5A5 → RVALID 1 cycle later, RDATA=0xA5A5A5A5, RRESP=00. Hold RREADY=0 for 4 cycles → RDATA and RVALID stable.
5. Same cycle: write reg0=0x1 and read 0x0 while reg0=0xFF → RDATA=0xFF. A following read returns 0x1.
6. Drop ARESETn while BVALID=1 and RVALID=1 → all outputs return to reset values immediately; registers read 0 after reset release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions used by both the master and the register slave.
// Holds response codes, bus widths and the slave's handshake state encodings.
package axi4_lite_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Small register array: one synchronous write port, one combinational read port,
// async active-low clear, and a flattened view of every register.
module axi4_lite_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata,
  output logic [DEPTH*WIDTH-1:0]   regs_flat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read is combinational, so a read registered on the same edge as a write sees the old value.
  assign rdata = mem[raddr];

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = mem[g];
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder for four software registers with independent write and read paths.
// Register contents are also exported in parallel on slv_regs.
module axi4_lite_slave_regs
  import axi4_lite_pkg::ADDR_W, axi4_lite_pkg::RESP_OKAY,
         axi4_lite_pkg::wr_state_t, axi4_lite_pkg::WR_IDLE, axi4_lite_pkg::WR_RESP,
         axi4_lite_pkg::rd_state_t, axi4_lite_pkg::RD_IDLE, axi4_lite_pkg::RD_DATA;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NUM_REGS*DATA_W-1:0] slv_regs
);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic              aw_held, w_held;
  logic [1:0]        aw_idx;
  logic [DATA_W-1:0] w_data;
  logic              aw_fire, w_fire, wr_en;
  logic [1:0]        wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0] rdata_q;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

  // Handshakes are derived from state and held flags rather than the READY outputs to keep logic acyclic.
  assign aw_fire = (wr_state == WR_IDLE) && !aw_held && AWVALID;
  assign w_fire  = (wr_state == WR_IDLE) && !w_held && WVALID;
  assign wr_en   = (wr_state == WR_IDLE) && (aw_held || AWVALID) && (w_held || WVALID);
  assign wr_idx  = aw_fire ? AWADDR[3:2] : aw_idx;
  assign wr_data = w_fire ? WDATA : w_data;

  always_comb begin
    wr_next = wr_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        AWREADY = !aw_held;
        WREADY  = !w_held;
        if (wr_en) wr_next = WR_RESP;
      end
      WR_RESP: begin
        BVALID = 1'b1;
        if (BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state <= WR_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
    end else begin
      wr_state <= wr_next;
      if (wr_en) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_fire) begin
          aw_held <= 1'b1;
          aw_idx  <= AWADDR[3:2];
        end
        if (w_fire) begin
          w_held <= 1'b1;
          w_data <= WDATA;
        end
      end
    end
  end

  always_comb begin
    rd_next = rd_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) rd_next = RD_DATA;
      end
      RD_DATA: begin
        RVALID = 1'b1;
        if (RREADY) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state <= RD_IDLE;
      rdata_q  <= '0;
    end else begin
      rd_state <= rd_next;
      if (rd_state == RD_IDLE && ARVALID) rdata_q <= rf_rdata;
    end
  end

  assign RDATA = rdata_q;
  assign BRESP = RESP_OKAY;
  assign RRESP = RESP_OKAY;

  axi4_lite_regfile #(
    .WIDTH(DATA_W),
    .DEPTH(NUM_REGS)
  ) u_regfile (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .we       (wr_en),
    .waddr    (wr_idx),
    .wdata    (wr_data),
    .raddr    (ARADDR[3:2]),
    .rdata    (rf_rdata),
    .regs_flat(slv_regs)
  );

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: directed scenarios then random traffic
// compared against a simple array model of the four registers.
module tb_axi4_lite_slave_regs;

  logic         ACLK;
  logic         ARESETn;
  logic [3:0]   AWADDR;
  logic         AWVALID;
  logic         AWREADY;
  logic [31:0]  WDATA;
  logic         WVALID;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic [3:0]   ARADDR;
  logic         ARVALID;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY;
  logic [127:0] slv_regs;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [4];

  axi4_lite_slave_regs dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .slv_regs(slv_regs)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Write with independent AW/W start delays and a B back-pressure period; stray AW/W offered during back-pressure must be ignored.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input int aw_delay, input int w_delay, input int b_delay);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_go, w_go;
    int cyc = 0;
    check("wr_awready_idle", 128'(AWREADY), 128'(1'b1));
    check("wr_wready_idle", 128'(WREADY), 128'(1'b1));
    BREADY = 1'b0;
    while (!(aw_done && w_done)) begin
      AWVALID = !aw_done && (cyc >= aw_delay);
      AWADDR  = addr;
      WVALID  = !w_done && (cyc >= w_delay);
      WDATA   = data;
      aw_go   = AWVALID && AWREADY;
      w_go    = WVALID && WREADY;
      tick();
      if (aw_go) aw_done = 1;
      if (w_go) w_done = 1;
      cyc++;
      if (!(aw_done && w_done)) begin
        check("wr_bvalid_early", 128'(BVALID), 128'(1'b0));
        check("wr_regs_early", slv_regs, model_flat());
        if (aw_done) check("wr_awready_gap", 128'(AWREADY), 128'(1'b0));
        if (w_done) check("wr_wready_gap", 128'(WREADY), 128'(1'b0));
        if (aw_done && !w_done) check("wr_wready_wait", 128'(WREADY), 128'(1'b1));
        if (w_done && !aw_done) check("wr_awready_wait", 128'(AWREADY), 128'(1'b1));
      end
      if (cyc > 50) begin
        checks++;
        errors++;
        $error("FAIL wr_timeout: observed no handshake after %0d cycles, expected handshake", cyc);
        break;
      end
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    model[addr[3:2]] = data;
    check("wr_bvalid", 128'(BVALID), 128'(1'b1));
    check("wr_bresp", 128'(BRESP), 128'(2'b00));
    check("wr_awready_resp", 128'(AWREADY), 128'(1'b0));
    check("wr_wready_resp", 128'(WREADY), 128'(1'b0));
    check("wr_regs", slv_regs, model_flat());
    for (int i = 0; i < b_delay; i++) begin
      AWVALID = 1'b1;
      AWADDR  = addr ^ 4'h4;
      WVALID  = 1'b1;
      WDATA   = ~data;
      tick();
      check("wr_bvalid_hold", 128'(BVALID), 128'(1'b1));
      check("wr_awready_hold", 128'(AWREADY), 128'(1'b0));
      check("wr_wready_hold", 128'(WREADY), 128'(1'b0));
    end
    BREADY = 1'b1;
    tick();
    BREADY  = 1'b0;
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("wr_bvalid_drop", 128'(BVALID), 128'(1'b0));
    check("wr_awready_back", 128'(AWREADY), 128'(1'b1));
    check("wr_wready_back", 128'(WREADY), 128'(1'b1));
    check("wr_regs_after", slv_regs, model_flat());
  endtask

  task automatic do_read(input logic [3:0] addr, input int r_delay);
    logic [31:0] exp;
    exp = model[addr[3:2]];
    check("rd_arready_idle", 128'(ARREADY), 128'(1'b1));
    ARVALID = 1'b1;
    ARADDR  = addr;
    RREADY  = 1'b0;
    tick();
    ARVALID = 1'b0;
    check("rd_rvalid", 128'(RVALID), 128'(1'b1));
    check("rd_rdata", 128'(RDATA), 128'(exp));
    check("rd_rresp", 128'(RRESP), 128'(2'b00));
    check("rd_arready_busy", 128'(ARREADY), 128'(1'b0));
    for (int i = 0; i < r_delay; i++) begin
      tick();
      check("rd_rvalid_hold", 128'(RVALID), 128'(1'b1));
      check("rd_rdata_hold", 128'(RDATA), 128'(exp));
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("rd_rvalid_drop", 128'(RVALID), 128'(1'b0));
    check("rd_arready_back", 128'(ARREADY), 128'(1'b1));
  endtask

  initial begin
    ARESETn = 1'b0;
    AWADDR  = '0;
    AWVALID = 1'b0;
    WDATA   = '0;
    WVALID  = 1'b0;
    BREADY  = 1'b0;
    ARADDR  = '0;
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;

    // Reset values
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_awready", 128'(AWREADY), 128'(1'b1));
    check("rst_wready", 128'(WREADY), 128'(1'b1));
    check("rst_arready", 128'(ARREADY), 128'(1'b1));
    check("rst_bvalid", 128'(BVALID), 128'(1'b0));
    check("rst_rvalid", 128'(RVALID), 128'(1'b0));
    check("rst_bresp", 128'(BRESP), 128'(2'b00));
    check("rst_rresp", 128'(RRESP), 128'(2'b00));
    check("rst_rdata", 128'(RDATA), 128'(32'h0));
    check("rst_regs", slv_regs, 128'h0);
    ARESETn = 1'b1;
    tick();

    // Same-cycle AW and W
    do_write(4'h4, 32'hDEADBEEF, 0, 0, 0);
    check("t1_reg1", 128'(slv_regs[63:32]), 128'(32'hDEADBEEF));

    // AW first then W three cycles later, and the reverse order
    do_write(4'h8, 32'h12345678, 0, 3, 0);
    check("t2_reg2", 128'(slv_regs[95:64]), 128'(32'h12345678));
    do_write(4'hC, 32'hCAFEF00D, 3, 0, 0);
    check("t2_reg3", 128'(slv_regs[127:96]), 128'(32'hCAFEF00D));

    // B back-pressure for five cycles
    do_write(4'h0, 32'h00000055, 0, 0, 5);

    // Read with aliased address and R back-pressure
    do_write(4'h4, 32'hA5A5A5A5, 1, 0, 0);
    do_read(4'h7, 4);

    // Simultaneous write and read of reg0
    do_write(4'h1, 32'h000000FF, 0, 0, 0);
    AWVALID = 1'b1;
    AWADDR  = 4'h0;
    WVALID  = 1'b1;
    WDATA   = 32'h1;
    ARVALID = 1'b1;
    ARADDR  = 4'h0;
    BREADY  = 1'b0;
    RREADY  = 1'b0;
    tick();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    ARVALID = 1'b0;
    model[0] = 32'h1;
    check("t5_rdata_old", 128'(RDATA), 128'(32'hFF));
    check("t5_bvalid", 128'(BVALID), 128'(1'b1));
    check("t5_rvalid", 128'(RVALID), 128'(1'b1));
    check("t5_regs", slv_regs, model_flat());
    BREADY = 1'b1;
    RREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    RREADY = 1'b0;
    check("t5_bvalid_drop", 128'(BVALID), 128'(1'b0));
    check("t5_rvalid_drop", 128'(RVALID), 128'(1'b0));
    do_read(4'h0, 0);

    // Reset while both B and R responses are pending
    AWVALID = 1'b1;
    AWADDR  = 4'h8;
    WVALID  = 1'b1;
    WDATA   = 32'h0BADF00D;
    ARVALID = 1'b1;
    ARADDR  = 4'h4;
    tick();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    ARVALID = 1'b0;
    check("t6_bvalid_pre", 128'(BVALID), 128'(1'b1));
    check("t6_rvalid_pre", 128'(RVALID), 128'(1'b1));
    #2;
    ARESETn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    check("t6_bvalid", 128'(BVALID), 128'(1'b0));
    check("t6_rvalid", 128'(RVALID), 128'(1'b0));
    check("t6_awready", 128'(AWREADY), 128'(1'b1));
    check("t6_wready", 128'(WREADY), 128'(1'b1));
    check("t6_arready", 128'(ARREADY), 128'(1'b1));
    check("t6_rdata", 128'(RDATA), 128'(32'h0));
    check("t6_regs", slv_regs, 128'h0);
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) do_read(4'(i * 4), 0);

    // Random traffic against the array model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        do_write(4'($urandom_range(0, 15)), 32'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else begin
        do_read(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      end
    end
    check("final_regs", slv_regs, model_flat());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
